param_seq_divider: RTL and testbench

Parametrised sequential restoring divider. Divides a 2*DW-bit dividend by a DW-bit divisor, producing a DW-bit quotient and a DW-bit remainder, one quotient bit per clock. Successor to the fixed 10/5-bit divider datapath/controller pair: width-generic, with an explicit BUSY handshake, held results and an optional signed mode. Sits as a standalone arithmetic unit driven by a Start pulse from a host controller.

---
 rtl/param_seq_divider.sv | 168 ++++++++++++++++
 tb/tb_param_seq_divider.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_seq_divider.sv
// rtl/param_seq_divider.sv - sequential restoring divider, 2*DW/DW bits; SIGNED_DIV_EN adds two's-complement mode
module param_seq_divider #(
  parameter int DW = 5
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Start,
  input  logic [2*DW-1:0] Dividend,
  input  logic [DW-1:0]   Divisor,
  output logic [DW-1:0]   Quo,
  output logic [DW-1:0]   Rem,
  output logic            BUSY,
  output logic            FINISH,
  output logic            OV,
  output logic            DIVBYZERO
);

  localparam int CNT_W = $clog2(DW + 1);

  typedef enum logic [2:0] {IDLE, LOAD, CALC, FIX, DONE} state_t;

  state_t            state, state_next;
  logic [2*DW-1:0]   dvd;
  logic [DW-1:0]     dvs;
  logic [2*DW-1:0]   dvd_mag;
  logic [DW-1:0]     dvs_mag;
  logic [DW-1:0]     pr;
  logic [DW-1:0]     sr;
  logic [CNT_W-1:0]  cnt;
  logic [DW-1:0]     quo_r;
  logic [DW-1:0]     rem_r;
  logic              ov_r;
  logic              dbz_r;
  logic [DW+1:0]     trial;
  logic              q_bit;
  logic [DW-1:0]     pr_next;
  logic [DW-1:0]     sr_next;
  logic              div_zero;
  logic              ov_load;
  logic              last;

`ifdef SIGNED_DIV_EN
  localparam logic [DW-1:0] HALF = {1'b1, {(DW-1){1'b0}}};
  logic q_neg;
  logic r_neg;
  assign dvd_mag = dvd[2*DW-1] ? -dvd : dvd;
  assign dvs_mag = dvs[DW-1] ? -dvs : dvs;
`else
  assign dvd_mag = dvd;
  assign dvs_mag = dvs;
`endif

  // The upper half must be below the divisor, otherwise the quotient needs more than DW bits
  assign div_zero = (dvs == '0);
  assign ov_load  = (dvd_mag[2*DW-1:DW] >= dvs_mag);
  assign last     = (cnt == CNT_W'(DW - 1));

  // Partial remainder is always below the divisor, so the trial difference fits DW bits when non-negative
  assign trial   = {1'b0, pr, sr[DW-1]} - {2'b00, dvs_mag};
  assign q_bit   = ~trial[DW+1];
  assign pr_next = q_bit ? trial[DW-1:0] : {pr[DW-2:0], sr[DW-1]};
  assign sr_next = {sr[DW-2:0], q_bit};

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (Start) state_next = LOAD;
      LOAD: state_next = (div_zero || ov_load) ? DONE : CALC;
      CALC: begin
        if (last) begin
`ifdef SIGNED_DIV_EN
          state_next = FIX;
`else
          state_next = DONE;
`endif
        end
      end
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, shift/subtract datapath and result registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      dvd   <= '0;
      dvs   <= '0;
      pr    <= '0;
      sr    <= '0;
      cnt   <= '0;
      quo_r <= '0;
      rem_r <= '0;
      ov_r  <= 1'b0;
      dbz_r <= 1'b0;
`ifdef SIGNED_DIV_EN
      q_neg <= 1'b0;
      r_neg <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            dvd   <= Dividend;
            dvs   <= Divisor;
            quo_r <= '0;
            rem_r <= '0;
            ov_r  <= 1'b0;
            dbz_r <= 1'b0;
          end
        end
        LOAD: begin
          if (div_zero) begin
            dbz_r <= 1'b1;
          end else if (ov_load) begin
            ov_r <= 1'b1;
          end else begin
            pr  <= dvd_mag[2*DW-1:DW];
            sr  <= dvd_mag[DW-1:0];
            cnt <= '0;
`ifdef SIGNED_DIV_EN
            q_neg <= dvd[2*DW-1] ^ dvs[DW-1];
            r_neg <= dvd[2*DW-1];
`endif
          end
        end
        CALC: begin
          pr  <= pr_next;
          sr  <= sr_next;
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            quo_r <= sr_next;
            rem_r <= pr_next;
          end
        end
        FIX: begin
`ifdef SIGNED_DIV_EN
          // A negative quotient may reach -2^(DW-1); a positive one stops at 2^(DW-1)-1
          if (q_neg ? (quo_r > HALF) : (quo_r >= HALF)) begin
            ov_r  <= 1'b1;
            quo_r <= '0;
            rem_r <= '0;
          end else begin
            if (q_neg) quo_r <= -quo_r;
            if (r_neg) rem_r <= -rem_r;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign Quo       = quo_r;
  assign Rem       = rem_r;
  assign OV        = ov_r;
  assign DIVBYZERO = dbz_r;
  assign BUSY      = (state != IDLE);
  assign FINISH    = (state == DONE);

endmodule

// File: tb/tb_param_seq_divider.sv
// tb/tb_param_seq_divider.sv - scoreboard bench for param_seq_divider; SIGNED_DIV_EN selects the signed model
module tb_param_seq_divider;

  localparam int DW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [2*DW-1:0] dividend;
  logic [DW-1:0]   divisor;
  logic [DW-1:0]   quo;
  logic [DW-1:0]   rem;
  logic            busy;
  logic            finish;
  logic            ov;
  logic            divbyzero;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [DW-1:0] quo;
    logic [DW-1:0] rem;
    logic          ov;
    logic          dz;
    int            lat;
  } exp_t;

  exp_t sb[$];

  param_seq_divider #(.DW(DW)) dut (
    .CLK(clk), .RST(rst), .Start(start), .Dividend(dividend), .Divisor(divisor),
    .Quo(quo), .Rem(rem), .BUSY(busy), .FINISH(finish), .OV(ov), .DIVBYZERO(divbyzero)
  );

  always #5 clk = ~clk;

  // Reference model: integer arithmetic, pushes the expected result for one operation
  task automatic push_expected(input logic [2*DW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    int   ai, bi, q, r;
    e.quo = '0; e.rem = '0; e.ov = 1'b0; e.dz = 1'b0; e.lat = 2;
`ifdef SIGNED_DIV_EN
    ai = int'(a) - (a[2*DW-1] ? (1 << (2*DW)) : 0);
    bi = int'(b) - (b[DW-1] ? (1 << DW) : 0);
    if (bi == 0) e.dz = 1'b1;
    else if (((ai < 0) ? -ai : ai) / ((bi < 0) ? -bi : bi) >= (1 << DW)) e.ov = 1'b1;
    else begin
      q = ai / bi;
      r = ai % bi;
      e.lat = DW + 3;
      if (q > (1 << (DW-1)) - 1 || q < -(1 << (DW-1))) e.ov = 1'b1;
      else begin
        e.quo = q[DW-1:0];
        e.rem = r[DW-1:0];
      end
    end
`else
    ai = int'(a);
    bi = int'(b);
    if (bi == 0) e.dz = 1'b1;
    else if (ai / bi >= (1 << DW)) e.ov = 1'b1;
    else begin
      q = ai / bi;
      r = ai % bi;
      e.quo = q[DW-1:0];
      e.rem = r[DW-1:0];
      e.lat = DW + 2;
    end
`endif
    sb.push_back(e);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of cycle 1
  task automatic start_op(input logic [2*DW-1:0] a, input logic [DW-1:0] b);
    start = 1'b1;
    dividend = a;
    divisor = b;
    push_expected(a, b);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for FINISH (bounded) and captures outputs; returns at the negedge of the following cycle
  task automatic collect(input int lat0, output logic [DW-1:0] q, output logic [DW-1:0] r,
                         output logic o, output logic z, output int lat, output bit busy_ok, output bit tmo);
    lat = lat0;
    busy_ok = 1'b1;
    while (!finish && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    tmo = !finish;
    q = quo; r = rem; o = ov; z = divbyzero;
    if (!busy) busy_ok = 1'b0;
    @(negedge clk);
    if (busy) busy_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({quo, rem, busy, finish, ov, divbyzero} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got quo=%0d rem=%0d busy=%b finish=%b ov=%b dz=%b, want all 0",
               quo, rem, busy, finish, ov, divbyzero);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [2*DW-1:0] ta [8] = '{10'd100, 10'd991, 10'd992, 10'd100, 10'd1023, 10'd0, 10'd500, 10'd1022};
    logic [DW-1:0]   tb [8] = '{5'd7, 5'd31, 5'd31, 5'd0, 5'd0, 5'd1, 5'd16, 5'd31};
    logic [DW-1:0] q, r;
    logic o, z;
    int lat;
    bit bok, tmo;
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      start_op(ta[i], tb[i]);
      collect(1, q, r, o, z, lat, bok, tmo);
      e = sb.pop_front();
      vectors++;
      if (tmo) begin miscompares++; $display("FAIL directed[%0d] timeout: no FINISH by cycle %0d", i, lat); continue; end
      vectors++;
      if ({q, r} !== {e.quo, e.rem}) begin miscompares++;
        $display("FAIL directed[%0d] result: got q=%0d r=%0d, want q=%0d r=%0d", i, q, r, e.quo, e.rem); end
      vectors++;
      if ({o, z} !== {e.ov, e.dz}) begin miscompares++;
        $display("FAIL directed[%0d] flags: got ov=%b dz=%b, want ov=%b dz=%b", i, o, z, e.ov, e.dz); end
      vectors++;
      if (lat !== e.lat) begin miscompares++;
        $display("FAIL directed[%0d] latency: got %0d, want %0d", i, lat, e.lat); end
      vectors++;
      if (!bok) begin miscompares++; $display("FAIL directed[%0d] busy: got bad BUSY window, want high to FINISH then low", i); end
    end
  endtask

  task automatic test_start_ignored();
    logic [DW-1:0] q, r;
    logic o, z;
    int lat;
    bit bok, tmo;
    exp_t e;
    start_op(10'd100, 5'd7);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 10'd50; divisor = 5'd5;
    @(negedge clk);
    start = 1'b0;
    collect(4, q, r, o, z, lat, bok, tmo);
    e = sb.pop_front();
    vectors++;
    if (tmo || {q, r, o, z} !== {e.quo, e.rem, e.ov, e.dz} || lat !== e.lat) begin miscompares++;
      $display("FAIL start_ignored: got q=%0d r=%0d ov=%b dz=%b lat=%0d, want q=%0d r=%0d ov=%b dz=%b lat=%0d",
               q, r, o, z, lat, e.quo, e.rem, e.ov, e.dz, e.lat); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if ({quo, rem, finish, busy} !== {e.quo, e.rem, 2'b00}) begin miscompares++;
        $display("FAIL held[%0d]: got q=%0d r=%0d finish=%b busy=%b, want q=%0d r=%0d idle",
                 i, quo, rem, finish, busy, e.quo, e.rem); end
    end
  endtask

  task automatic test_reset_abort();
    logic [DW-1:0] q, r;
    logic o, z;
    int lat;
    bit bok, tmo;
    exp_t e;
    start_op(10'd100, 5'd0);
    collect(1, q, r, o, z, lat, bok, tmo);
    e = sb.pop_front();
    vectors++;
    if (tmo || z !== e.dz) begin miscompares++; $display("FAIL abort_pre dz: got %b, want %b", z, e.dz); end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({quo, rem, busy, finish, ov, divbyzero} !== '0) begin miscompares++;
      $display("FAIL idle_reset: got q=%0d r=%0d dz=%b, want all 0", quo, rem, divbyzero); end
    rst = 1'b0;
    start_op(10'd100, 5'd7);
    void'(sb.pop_back());
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({quo, rem, busy, finish, ov, divbyzero} !== '0) begin miscompares++;
      $display("FAIL mid_reset: got q=%0d r=%0d busy=%b finish=%b ov=%b dz=%b, want all 0",
               quo, rem, busy, finish, ov, divbyzero); end
    rst = 1'b0;
    start_op(10'd991, 5'd31);
    collect(1, q, r, o, z, lat, bok, tmo);
    e = sb.pop_front();
    vectors++;
    if (tmo || {q, r, o, z} !== {e.quo, e.rem, e.ov, e.dz} || lat !== e.lat || !bok) begin miscompares++;
      $display("FAIL after_reset: got q=%0d r=%0d ov=%b dz=%b lat=%0d, want q=%0d r=%0d ov=%b dz=%b lat=%0d",
               q, r, o, z, lat, e.quo, e.rem, e.ov, e.dz, e.lat); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] q, r;
    logic o, z;
    int lat, a, b;
    bit bok, tmo;
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 3) begin
        a = $urandom_range(0, (1 << (2*DW)) - 1);
        b = $urandom_range(0, (1 << DW) - 1);
      end else begin
        b = $urandom_range(1, (1 << DW) - 1);
        a = $urandom_range(0, (1 << DW) - 1) * b + $urandom_range(0, b - 1);
      end
      start_op(a[2*DW-1:0], b[DW-1:0]);
      collect(1, q, r, o, z, lat, bok, tmo);
      e = sb.pop_front();
      vectors++;
      if (tmo || {q, r, o, z} !== {e.quo, e.rem, e.ov, e.dz} || lat !== e.lat || !bok) begin miscompares++;
        $display("FAIL b2b[%0d] %0d/%0d: got q=%0d r=%0d ov=%b dz=%b lat=%0d, want q=%0d r=%0d ov=%b dz=%b lat=%0d",
                 i, a, b, q, r, o, z, lat, e.quo, e.rem, e.ov, e.dz, e.lat); end
    end
  endtask

`ifdef SIGNED_DIV_EN
  task automatic test_signed();
    logic [2*DW-1:0] ta [5] = '{10'd924, 10'd512, 10'd100, 10'd1008, 10'd16};
    logic [DW-1:0]   tb [5] = '{5'd7, 5'd1, 5'd25, 5'd1, 5'd1};
    logic [DW-1:0] q, r;
    logic o, z;
    int lat;
    bit bok, tmo;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      start_op(ta[i], tb[i]);
      collect(1, q, r, o, z, lat, bok, tmo);
      e = sb.pop_front();
      vectors++;
      if (tmo || {q, r, o, z} !== {e.quo, e.rem, e.ov, e.dz} || lat !== e.lat || !bok) begin miscompares++;
        $display("FAIL signed[%0d]: got q=%b r=%b ov=%b dz=%b lat=%0d, want q=%b r=%b ov=%b dz=%b lat=%0d",
                 i, q, r, o, z, lat, e.quo, e.rem, e.ov, e.dz, e.lat); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
`ifdef SIGNED_DIV_EN
    test_signed();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
